// File: rtl/build_length_16bit.sv
// rtl/build_length_16bit.sv - builds a 16-bit one-hot/mask vector top-down from a 4-bit index
module build_length_16bit (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [3:0] len_i,
   input  logic       mode_i,
   input  logic       abort_i,
   output logic       data_o [0:15],
   output logic       ready_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] work_q, work_d;
   logic [15:0] data_q, data_d;
   logic [3:0]  len_q, len_d;
   logic        mode_q, mode_d;

   // Bit value for the current index and the work word with that bit applied;
   // the completing edge publishes this word so bit 0 is included.
   logic        bit_val;
   logic [15:0] work_wr;

   // Compute the bit for the index under the down-counter and merge it into the work word.
   always_comb begin
      bit_val = (cnt_q == len_q) | (mode_q & (cnt_q < len_q));
      work_wr = work_q;
      work_wr[cnt_q] = bit_val;
   end

   // Next-state logic: accept in IDLE, one bit per edge in BUILD, one-cycle DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      data_d  = data_q;
      len_d   = len_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d   = len_i;
               mode_d  = mode_i;
               work_d  = 16'h0000;
               cnt_d   = 4'hF;
               state_d = BUILD;
            end
         end
         BUILD: begin
            // Abort wins over completion, so a late abort never publishes.
            if (abort_i) begin
               state_d = IDLE;
            end else begin
               work_d = work_wr;
               if (cnt_q == 4'd0) begin
                  data_d  = work_wr;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with asynchronous active-high reset clearing everything.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         work_q  <= 16'h0000;
         data_q  <= 16'h0000;
         len_q   <= 4'd0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         data_q  <= data_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
      end
   end

   // Status outputs are gated by reset so they read low while reset is held.
   always_comb begin
      ready_o = (state_q == IDLE)  & ~rst_i;
      busy_o  = (state_q == BUILD) & ~rst_i;
      done_o  = (state_q == DONE)  & ~rst_i;
   end

   // Present the published word as an unpacked vector, index 15 at the top.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         data_o[i] = data_q[i];
      end
   end

endmodule
